// File: rtl/pe_out_fifo_pkg.sv
// pe_out_fifo_pkg: shared PE definitions used by the PE output buffer.
//   IF_W, FILT_W : input-feature and filter word widths of the PE datapath.
//   PE_OUT_W     : width of one accumulated partial sum (IF_W + FILT_W + 1).
//   clog2()      : ceiling log2, used to size pointers from the buffer depth.
package pe_out_fifo_pkg;

  localparam int IF_W     = 16;
  localparam int FILT_W   = 16;
  localparam int PE_OUT_W = IF_W + FILT_W + 1;

  // Smallest r with 2**r >= value; evaluated at elaboration time only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_out_fifo_ctrl.sv
// pe_out_fifo_ctrl: bookkeeping for the PE output buffer.
//   Holds the read/write pointers, the entry count, the output-valid flag and
//   the sticky overflow flag, and decides when a write is accepted (push) and
//   when the head entry moves into the output register (pop).
// Ports:
//   clk, rst (async, active high), clr (sync flush)
//   wen, rd_ready          : PE write strobe, downstream ready
//   push, pop              : accepted write / head-to-output transfer this cycle
//   wptr, rptr             : array addresses for the write and the read
//   count, full, empty     : array occupancy status
//   dout_valid, overflow   : output-register valid, sticky dropped-write flag
module pe_out_fifo_ctrl
  import pe_out_fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ADDR_LEN = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wen,
  input  logic                rd_ready,
  output logic                push,
  output logic                pop,
  output logic [ADDR_LEN-1:0] wptr,
  output logic [ADDR_LEN-1:0] rptr,
  output logic [ADDR_LEN:0]   count,
  output logic                full,
  output logic                empty,
  output logic                dout_valid,
  output logic                overflow
);

  localparam logic [ADDR_LEN:0] FULL_COUNT = (ADDR_LEN+1)'(DEPTH);
  localparam logic [ADDR_LEN:0] ZERO_COUNT = {(ADDR_LEN+1){1'b0}};

  // Status flags and transfer decisions. full deliberately ignores a pop in the
  // same cycle so the PE sees a simple, registered-count-based back-pressure.
  always_comb begin
    full  = (count == FULL_COUNT);
    empty = (count == ZERO_COUNT) && !dout_valid;
    push  = wen && !full;
    pop   = (count != ZERO_COUNT) && (!dout_valid || rd_ready);
  end

  // Pointer, count, valid and overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= {ADDR_LEN{1'b0}};
      rptr       <= {ADDR_LEN{1'b0}};
      count      <= ZERO_COUNT;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (clr) begin
      wptr       <= {ADDR_LEN{1'b0}};
      rptr       <= {ADDR_LEN{1'b0}};
      count      <= ZERO_COUNT;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Without a pop, an accepted handshake can only leave the register empty.
      if (pop) begin
        dout_valid <= 1'b1;
      end else if (rd_ready) begin
        dout_valid <= 1'b0;
      end
      if (wen && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_out_fifo.sv
// pe_out_fifo: output buffer between the PE datapath and the next stage.
//   Words written by the PE go into a circular register array, then through a
//   registered output stage (dout) that drains over a valid/ready handshake.
//   Total storage is DEPTH array entries plus the output register.
// Ports:
//   clk, rst (async, active high), clr (sync flush of all state)
//   wen, din          : PE write strobe and data
//   full              : array holds DEPTH entries (to the PE)
//   rd_ready          : downstream accepts dout
//   dout, dout_valid  : output register and its valid flag
//   empty             : array and output register both empty
//   count             : array occupancy, excluding the output register
//   overflow          : sticky, a write arrived while full
module pe_out_fifo
  import pe_out_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = PE_OUT_W,
  parameter int DEPTH      = 8,
  parameter int ADDR_LEN   = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic [ADDR_LEN:0]     count,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_LEN-1:0]   wptr;
  logic [ADDR_LEN-1:0]   rptr;
  logic                  push;
  logic                  pop;

  pe_out_fifo_ctrl #(
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wen        (wen),
    .rd_ready   (rd_ready),
    .push       (push),
    .pop        (pop),
    .wptr       (wptr),
    .rptr       (rptr),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .dout_valid (dout_valid),
    .overflow   (overflow)
  );

  // Storage array: plain registers, contents are don't-care after a flush.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wptr] <= din;
    end
  end

  // Output register: loads the array head on pop, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= {DATA_WIDTH{1'b0}};
    end else if (clr) begin
      dout <= {DATA_WIDTH{1'b0}};
    end else if (pop) begin
      dout <= mem[rptr];
    end else begin
      dout <= dout;
    end
  end

endmodule
